// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller side consumes opcode/conditions and drives the enables.
interface multicycle_ctrl_if;
   logic [5:0] opcode;
   logic       br_cond;
   logic       imem_ready;
   logic       dmem_ready;
   logic       PCWrite;
   logic [1:0] PCSrc;
   logic       IRWrite;
   logic       RegDst;
   logic       RegWrite;
   logic       LinkWrite;
   logic       ExtOp;
   logic       ALUSrc;
   logic       MemRd;
   logic       MemWrite;
   logic       WBdata;
   logic [2:0] state;
   logic       instr_done;
   logic       illegal;

   modport master (
      input  opcode, br_cond, imem_ready, dmem_ready,
      output PCWrite, PCSrc, IRWrite, RegDst, RegWrite,
      output LinkWrite, ExtOp, ALUSrc, MemRd, MemWrite,
      output WBdata, state, instr_done, illegal
   );

   modport slave (
      output opcode, br_cond, imem_ready, dmem_ready,
      input  PCWrite, PCSrc, IRWrite, RegDst, RegWrite,
      input  LinkWrite, ExtOp, ALUSrc, MemRd, MemWrite,
      input  WBdata, state, instr_done, illegal
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with ready stalls.
// Outputs are combinational; reset forces every output low in its cycle.
module multicycle_ctrl (
   input  logic                   clk,
   input  logic                   rst,
   multicycle_ctrl_if.master      bus
);
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [5:0] op_q;
   logic [5:0] op_sel;

   logic is_r, is_andi, is_addi, is_lw, is_sw;
   logic is_br, is_j, is_jal;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == DECODE)
            op_q <= bus.opcode;
      end
   end

   // DECODE acts on the live opcode; later states use the latched copy.
   assign op_sel  = (state_q == DECODE) ? bus.opcode : op_q;

   assign is_r    = (op_sel <= 6'd2);
   assign is_andi = (op_sel == 6'd3);
   assign is_addi = (op_sel == 6'd4);
   assign is_lw   = (op_sel == 6'd5) || (op_sel == 6'd6);
   assign is_sw   = (op_sel == 6'd7);
   assign is_br   = (op_sel[5:2] == 4'b0010);
   assign is_j    = (op_sel == 6'd12);
   assign is_jal  = (op_sel == 6'd13);

   always_comb begin
      state_d        = FETCH;
      bus.PCWrite    = 1'b0;
      bus.PCSrc      = 2'b00;
      bus.IRWrite    = 1'b0;
      bus.RegDst     = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.LinkWrite  = 1'b0;
      bus.ExtOp      = 1'b0;
      bus.ALUSrc     = 1'b0;
      bus.MemRd      = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.WBdata     = 1'b0;
      bus.instr_done = 1'b0;
      bus.illegal    = 1'b0;
      bus.state      = 3'd0;

      if (!rst) begin
         bus.state = state_q;
         unique case (state_q)
            FETCH: begin
               bus.IRWrite = bus.imem_ready;
               bus.PCWrite = bus.imem_ready;
               state_d     = bus.imem_ready ? DECODE : FETCH;
            end
            DECODE: begin
               if (is_j || is_jal) begin
                  bus.PCWrite    = 1'b1;
                  bus.PCSrc      = 2'b10;
                  bus.RegWrite   = is_jal;
                  bus.LinkWrite  = is_jal;
                  bus.instr_done = 1'b1;
                  state_d        = FETCH;
               end else if (is_r || is_andi || is_addi ||
                            is_lw || is_sw || is_br) begin
                  state_d = EXEC;
               end else begin
                  bus.illegal    = 1'b1;
                  bus.instr_done = 1'b1;
                  state_d        = FETCH;
               end
            end
            EXEC: begin
               bus.ExtOp  = is_addi | is_lw | is_sw | is_br;
               bus.ALUSrc = is_andi | is_addi | is_lw | is_sw;
               bus.RegDst = is_r;
               if (is_r || is_andi || is_addi) begin
                  state_d = WB;
               end else if (is_lw || is_sw) begin
                  state_d = MEM;
               end else if (is_br) begin
                  bus.PCWrite    = bus.br_cond;
                  bus.PCSrc      = 2'b01;
                  bus.instr_done = 1'b1;
                  state_d        = FETCH;
               end
            end
            MEM: begin
               bus.ExtOp    = 1'b1;
               bus.ALUSrc   = 1'b1;
               bus.MemRd    = is_lw;
               bus.MemWrite = is_sw;
               if (!bus.dmem_ready) begin
                  state_d = MEM;
               end else if (is_lw) begin
                  state_d = WB;
               end else begin
                  bus.instr_done = is_sw;
                  state_d        = FETCH;
               end
            end
            WB: begin
               bus.ExtOp      = is_addi | is_lw;
               bus.ALUSrc     = is_andi | is_addi | is_lw;
               bus.RegDst     = is_r;
               bus.RegWrite   = 1'b1;
               bus.WBdata     = is_lw;
               bus.instr_done = 1'b1;
               state_d        = FETCH;
            end
            default: begin
               state_d = FETCH;
            end
         endcase
      end
   end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- opcode  in  6  instruction opcode from IR, valid from DECODE onward
- br_cond  in  1  branch-taken from ALU/comparator, valid in EXEC
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- PCWrite  out  1  PC load enable
- PCSrc  out  2  00 PC+1, 01 branch target, 10 jump target
- IRWrite  out  1  IR load enable
- RegDst  out  1  1 = rd, 0 = rt
- RegWrite  out  1  register file write enable
- LinkWrite  out  1  write return address (PC) to link register
- ExtOp  out  1  1 = sign-extend, 0 = zero-extend
- ALUSrc  out  1  1 = immediate, 0 = register
- MemRd  out  1  data memory read
- MemWrite  out  1  data memory write
- WBdata  out  1  0 = ALU result, 1 = memory data
- state  out  3  current state encoding
- instr_done  out  1  pulse on last cycle of each instruction
- illegal  out  1  pulse on undefined opcode
REQ-003 Opcode classes SHALL be: 000000-000010 R-type; 000011 ANDI; 000100 ADDI; 000101, 000110 LW; 000111 SW; 001000-001011 branch; 001100 J; 001101 JAL; all others undefined.

Function
REQ-004 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL transition to FETCH with all outputs 0.
REQ-005 Outputs SHALL be combinational from state, op_q (DECODE: live opcode), br_cond and ready inputs; every output not listed as asserted in a state SHALL be 0 (no don't-cares).
REQ-006 FETCH: IRWrite=PCWrite=imem_ready, PCSrc=00; stay while imem_ready=0; on imem_ready=1 go to DECODE.
REQ-007 DECODE: op_q SHALL capture opcode at the clock edge leaving DECODE.
REQ-008 DECODE next state: R-type/ANDI/ADDI/LW/SW/branch -> EXEC; J/JAL -> FETCH; undefined -> FETCH.
REQ-009 DECODE with J: PCWrite=1, PCSrc=10, instr_done=1.
REQ-010 DECODE with JAL: as J, plus RegWrite=1, LinkWrite=1.
REQ-011 DECODE with undefined opcode: illegal=1, instr_done=1, no PC/register/memory write.
REQ-012 EXEC: ALUSrc=1 for ANDI/ADDI/LW/SW, else 0.
REQ-013 EXEC: ExtOp=0 for ANDI, 1 for ADDI/LW/SW/branch, 0 for R-type.
REQ-014 EXEC next state: R-type/ANDI/ADDI -> WB; LW/SW -> MEM; branch -> FETCH.
REQ-015 EXEC branch: PCWrite=br_cond, PCSrc=01, instr_done=1.
REQ-016 MEM: MemRd=1 (LW) or MemWrite=1 (SW), held while dmem_ready=0.
REQ-017 MEM on dmem_ready=1: LW -> WB; SW -> FETCH with instr_done=1.
REQ-018 WB: RegWrite=1, instr_done=1, next FETCH.
REQ-019 WB: RegDst=1 for R-type, else 0.
REQ-020 WB: WBdata=1 for LW, else 0.
REQ-021 Cycle counts with ready inputs tied high SHALL be: J/JAL 2; branch 3; R-type/ANDI/ADDI/SW 4; LW 5. Each wait cycle adds exactly one cycle.
REQ-022 ExtOp, ALUSrc and RegDst SHALL hold their EXEC values through MEM and WB of the same instruction.
REQ-023 instr_done and illegal SHALL each be high for exactly one cycle per instruction.

Reset
REQ-024 While rst=1 all outputs SHALL be 0 in that cycle, including MemWrite mid-MEM.
REQ-025 On the first edge with rst=1, state SHALL become FETCH and op_q SHALL become 000000.
REQ-026 Reset asserted mid-instruction SHALL abort it without instr_done; the first cycle after rst deasserts SHALL be FETCH.

Verification
REQ-027 ADDI (000100), readies high -> states 0,1,2,4; WB RegWrite=1, WBdata=0, RegDst=0; EXEC ExtOp=1, ALUSrc=1; instr_done in cycle 4 only.
REQ-028 LW (000101), dmem_ready low 3 MEM cycles -> MemRd=1 for 4 MEM cycles; WB WBdata=1, RegWrite=1; total 8 cycles.
REQ-029 Branch 001000: br_cond=1 -> EXEC PCWrite=1, PCSrc=01; br_cond=0 -> PCWrite=0; both return to FETCH after 3 cycles.
REQ-030 JAL 001101 -> DECODE PCWrite=1, PCSrc=10, RegWrite=1, LinkWrite=1; next state FETCH.
REQ-031 Opcode 111111 -> illegal=1 in DECODE, all write enables 0, next FETCH.
REQ-032 SW in MEM with dmem_ready=0, rst=1 -> MemWrite=0 that cycle; state=0 next cycle; no instr_done.
